traffic_analyzer_gmii_mc: RTL
=============================

Name: traffic_analyzer_gmii_mc

Overview:
Multi-channel, parametrised successor of the single-port GMII traffic analyzer. Monitors NUM_CH independent GMII receive streams on one clock and keeps per-channel statistics: frames, octets, idle octets, errored frames, bad-preamble frames, last-frame timestamp and last-frame size. Statistics are exposed through a snapshot shadow bank and a simple 1-cycle-latency read port. An AXI-Lite register wrapper sits on top of that read port.

Parameters:
NUM_CH, 4, number of GMII channels (1..16)
CNT_WIDTH, 64, width of the pkts/octets/idle/err/bad-preamble counters
SEC_WIDTH, 48, width of the sec timestamp input
NSEC_WIDTH, 30, width of the nsec timestamp input
SIZE_WIDTH, 16, width of the last-frame-size register

Ports:
clk  in  1  analyzer clock; all GMII inputs are sampled on its rising edge
resetn  in  1  asynchronous active-low reset
gmii_d  in  NUM_CH*8  channel c data at [8c+7:8c]
gmii_en  in  NUM_CH  per-channel data valid
gmii_er  in  NUM_CH  per-channel receive error
sec  in  SEC_WIDTH  RTC seconds
nsec  in  NSEC_WIDTH  RTC nanoseconds
clear  in  1  one-cycle pulse: zero all live counters on all channels
snapshot  in  1  one-cycle pulse: copy all live statistics into the shadow bank
snapshot_done  out  1  one-cycle pulse, asserted the cycle after the shadow bank is updated
rd_en  in  1  read strobe
rd_ch  in  max(1,clog2(NUM_CH))  channel select
rd_sel  in  3  0 pkts, 1 octets, 2 octets_idle, 3 err_pkts, 4 bad_pre_pkts, 5 ts_sec, 6 ts_nsec, 7 last_size
rd_data  out  CNT_WIDTH  shadow value, zero-extended
rd_valid  out  1  rd_data valid

Behaviour:
- Reset: all live counters, shadow registers, per-channel FSMs, rd_data, rd_valid and snapshot_done go to 0. Reset is asynchronous on assertion.
- Per-channel FSM states: IDLE and FRAME.
  - IDLE -> FRAME when gmii_en=1. The start cycle latches {sec,nsec} into pending_ts, sets len=1, and begins preamble checking on byte 0.
  - FRAME -> IDLE on the first cycle with gmii_en=0. That end cycle:
    - pkts += 1.
    - err_pkts += 1 if gmii_er was seen on any en cycle of the frame.
    - bad_pre_pkts += 1 if bytes 0..6 != 0x55, byte 7 != 0xD5, or len < 8.
    - ts <= pending_ts; last_size <= len, saturating at 2^SIZE_WIDTH-1.
  - Back-to-back frames need at least one en=0 cycle between them; en held high is always one frame.
- octets += 1 on every cycle with gmii_en=1. Preamble/SFD bytes are included.
- octets_idle += 1 on every cycle with gmii_en=0.
- All counters wrap modulo 2^CNT_WIDTH; there is no saturation.
- clear:
  - Zeroes pkts, octets, octets_idle, err_pkts and bad_pre_pkts on all channels. ts, last_size and the shadow bank are not touched.
  - If a frame end or octet increment coincides with clear, clear wins and the event is dropped.
  - A frame in progress during clear is still counted at its end. Its octets after clear are counted.
- snapshot:
  - Shadow bank <= live values, taken from the same cycle for all channels and all fields (atomic, no 64-bit tearing).
  - snapshot_done pulses on the next cycle.
  - snapshot and clear in the same cycle: shadow gets the pre-clear values, then live counters are zeroed.
- Read port:
  - rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1, with rd_valid=0 otherwise.
  - rd_ch >= NUM_CH returns 0 with rd_valid=1.
  - A read that coincides with snapshot returns the pre-snapshot shadow value.
- Reset asserted mid-frame: FSM returns to IDLE and the partial frame is discarded. After reset release, a channel with en already high is treated as a new frame starting on the first sampled cycle.
- Channels are fully independent; no arbitration between them.

Test Plan:
- Reset, snapshot, then read all 8 selects on every channel: every rd_data = 0.
- Ch0: 10 frames of 72 bytes (55x7, D5, 64 payload), 12 idle cycles between frames; then snapshot. Required: pkts=10, octets=720, last_size=72, err_pkts=0, bad_pre_pkts=0, octets_idle >= 108; ch1..3 pkts=0.
- Ch2: one 72-byte frame with gmii_er high on byte 30, and one frame with byte 7 = 0xD4. Required: pkts=2, err_pkts=1, bad_pre_pkts=1; a 5-byte frame adds one more to bad_pre_pkts.
- Ch1 frame started at sec=3, nsec=1000: after snapshot, ts_sec=3 and ts_nsec=1000. A second frame on ch1 without a new snapshot leaves the shadow unchanged.
- clear and snapshot in the same cycle after 4 frames on ch3: shadow pkts=4. A following snapshot with no traffic gives pkts=0 and octets=0.
- Force octets to 2^CNT_WIDTH-1 (small CNT_WIDTH=8 build), send one byte: octets wraps to 0. A frame longer than 2^SIZE_WIDTH-1 bytes (SIZE_WIDTH=4 build) gives last_size=15.

Source files
------------

// File: rtl/traffic_analyzer_gmii_mc_if.sv
// GMII receive bundle, control pulses and statistics read port of the multi-channel analyzer.
// master = stimulus/host side, slave = analyzer side.
interface traffic_analyzer_gmii_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int SEC_WIDTH  = 48,
  parameter int NSEC_WIDTH = 30
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*8-1:0]   gmii_d;
  logic [NUM_CH-1:0]     gmii_en;
  logic [NUM_CH-1:0]     gmii_er;
  logic [SEC_WIDTH-1:0]  sec;
  logic [NSEC_WIDTH-1:0] nsec;
  logic                  clear;
  logic                  snapshot;
  logic                  snapshot_done;
  logic                  rd_en;
  logic [CH_W-1:0]       rd_ch;
  logic [2:0]            rd_sel;
  logic [CNT_WIDTH-1:0]  rd_data;
  logic                  rd_valid;

  modport master (
    output gmii_d, gmii_en, gmii_er, sec, nsec, clear, snapshot, rd_en, rd_ch, rd_sel,
    input  snapshot_done, rd_data, rd_valid
  );

  modport slave (
    input  gmii_d, gmii_en, gmii_er, sec, nsec, clear, snapshot, rd_en, rd_ch, rd_sel,
    output snapshot_done, rd_data, rd_valid
  );
endinterface

// File: rtl/traffic_analyzer_gmii_mc.sv
// Per-channel GMII statistics (frames, octets, idle, errors, bad preamble, timestamp, size) with an
// atomic shadow bank; reads return shadow data one cycle after rd_en, no backpressure.
module traffic_analyzer_gmii_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int SEC_WIDTH  = 48,
  parameter int NSEC_WIDTH = 30,
  parameter int SIZE_WIDTH = 16
) (
  input logic                     clk,
  input logic                     resetn,
  traffic_analyzer_gmii_mc_if.slave bus
);
  localparam int W1 = (CNT_WIDTH > SEC_WIDTH) ? CNT_WIDTH : SEC_WIDTH;
  localparam int W2 = (W1 > NSEC_WIDTH) ? W1 : NSEC_WIDTH;
  localparam int WW = (W2 > SIZE_WIDTH) ? W2 : SIZE_WIDTH;

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  state_t                state_q     [NUM_CH];
  state_t                state_d     [NUM_CH];
  logic [SIZE_WIDTH-1:0] len_q       [NUM_CH];
  logic [SIZE_WIDTH-1:0] len_d       [NUM_CH];
  logic [3:0]            pos_q       [NUM_CH];
  logic [3:0]            pos_d       [NUM_CH];
  logic [NUM_CH-1:0]     err_q, err_d, bad_q, bad_d;
  logic [SEC_WIDTH-1:0]  pts_sec_q   [NUM_CH];
  logic [SEC_WIDTH-1:0]  pts_sec_d   [NUM_CH];
  logic [NSEC_WIDTH-1:0] pts_nsec_q  [NUM_CH];
  logic [NSEC_WIDTH-1:0] pts_nsec_d  [NUM_CH];
  logic [SEC_WIDTH-1:0]  ts_sec_q    [NUM_CH];
  logic [SEC_WIDTH-1:0]  ts_sec_d    [NUM_CH];
  logic [NSEC_WIDTH-1:0] ts_nsec_q   [NUM_CH];
  logic [NSEC_WIDTH-1:0] ts_nsec_d   [NUM_CH];
  logic [SIZE_WIDTH-1:0] last_size_q [NUM_CH];
  logic [SIZE_WIDTH-1:0] last_size_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  pkts_q [NUM_CH], pkts_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  oct_q  [NUM_CH], oct_d  [NUM_CH];
  logic [CNT_WIDTH-1:0]  idle_q [NUM_CH], idle_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  errp_q [NUM_CH], errp_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  badp_q [NUM_CH], badp_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  sh_q   [NUM_CH][8];
  logic [NUM_CH-1:0]     frame_end;
  logic                  snapshot_done_q;
  logic                  rd_valid_q;
  logic [CNT_WIDTH-1:0]  rd_data_q;

  function automatic logic [CNT_WIDTH-1:0] zext(input logic [WW-1:0] v);
    return v[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    frame_end = '0;
    err_d     = err_q;
    bad_d     = bad_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]     = state_q[c];
      len_d[c]       = len_q[c];
      pos_d[c]       = pos_q[c];
      pts_sec_d[c]   = pts_sec_q[c];
      pts_nsec_d[c]  = pts_nsec_q[c];
      ts_sec_d[c]    = ts_sec_q[c];
      ts_nsec_d[c]   = ts_nsec_q[c];
      last_size_d[c] = last_size_q[c];
      pkts_d[c]      = pkts_q[c];
      oct_d[c]       = oct_q[c];
      idle_d[c]      = idle_q[c];
      errp_d[c]      = errp_q[c];
      badp_d[c]      = badp_q[c];

      unique case (state_q[c])
        S_IDLE: begin
          if (bus.gmii_en[c]) begin
            state_d[c]    = S_FRAME;
            pts_sec_d[c]  = bus.sec;
            pts_nsec_d[c] = bus.nsec;
            len_d[c]      = SIZE_WIDTH'(1);
            pos_d[c]      = 4'd1;
            err_d[c]      = bus.gmii_er[c];
            bad_d[c]      = (bus.gmii_d[8*c +: 8] != 8'h55);
          end
        end
        S_FRAME: begin
          if (bus.gmii_en[c]) begin
            len_d[c] = (&len_q[c]) ? len_q[c] : len_q[c] + SIZE_WIDTH'(1);
            if (pos_q[c] < 4'd8) pos_d[c] = pos_q[c] + 4'd1;
            if (pos_q[c] < 4'd7 && bus.gmii_d[8*c +: 8] != 8'h55) bad_d[c] = 1'b1;
            if (pos_q[c] == 4'd7 && bus.gmii_d[8*c +: 8] != 8'hD5) bad_d[c] = 1'b1;
            err_d[c] = err_q[c] | bus.gmii_er[c];
          end else begin
            state_d[c]     = S_IDLE;
            frame_end[c]   = 1'b1;
            ts_sec_d[c]    = pts_sec_q[c];
            ts_nsec_d[c]   = pts_nsec_q[c];
            last_size_d[c] = len_q[c];
          end
        end
        default: state_d[c] = S_IDLE;
      endcase

      // clear drops any increment landing in the same cycle; frame tracking is untouched
      if (bus.clear) begin
        pkts_d[c] = '0;
        oct_d[c]  = '0;
        idle_d[c] = '0;
        errp_d[c] = '0;
        badp_d[c] = '0;
      end else begin
        if (bus.gmii_en[c]) oct_d[c]  = oct_q[c] + CNT_WIDTH'(1);
        else                idle_d[c] = idle_q[c] + CNT_WIDTH'(1);
        if (frame_end[c]) begin
          pkts_d[c] = pkts_q[c] + CNT_WIDTH'(1);
          errp_d[c] = errp_q[c] + CNT_WIDTH'(err_q[c]);
          badp_d[c] = badp_q[c] + CNT_WIDTH'(bad_q[c] || pos_q[c] < 4'd8);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q           <= '0;
      bad_q           <= '0;
      snapshot_done_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= S_IDLE;
        len_q[c]       <= '0;
        pos_q[c]       <= '0;
        pts_sec_q[c]   <= '0;
        pts_nsec_q[c]  <= '0;
        ts_sec_q[c]    <= '0;
        ts_nsec_q[c]   <= '0;
        last_size_q[c] <= '0;
        pkts_q[c]      <= '0;
        oct_q[c]       <= '0;
        idle_q[c]      <= '0;
        errp_q[c]      <= '0;
        badp_q[c]      <= '0;
        for (int s = 0; s < 8; s++) sh_q[c][s] <= '0;
      end
    end else begin
      err_q           <= err_d;
      bad_q           <= bad_d;
      snapshot_done_q <= bus.snapshot;
      rd_valid_q      <= bus.rd_en;
      // shadow is read before the snapshot write lands, so a coinciding read sees old data
      if (bus.rd_en) begin
        rd_data_q <= (int'(bus.rd_ch) < NUM_CH) ? sh_q[bus.rd_ch][bus.rd_sel] : '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= state_d[c];
        len_q[c]       <= len_d[c];
        pos_q[c]       <= pos_d[c];
        pts_sec_q[c]   <= pts_sec_d[c];
        pts_nsec_q[c]  <= pts_nsec_d[c];
        ts_sec_q[c]    <= ts_sec_d[c];
        ts_nsec_q[c]   <= ts_nsec_d[c];
        last_size_q[c] <= last_size_d[c];
        pkts_q[c]      <= pkts_d[c];
        oct_q[c]       <= oct_d[c];
        idle_q[c]      <= idle_d[c];
        errp_q[c]      <= errp_d[c];
        badp_q[c]      <= badp_d[c];
        if (bus.snapshot) begin
          sh_q[c][0] <= pkts_q[c];
          sh_q[c][1] <= oct_q[c];
          sh_q[c][2] <= idle_q[c];
          sh_q[c][3] <= errp_q[c];
          sh_q[c][4] <= badp_q[c];
          sh_q[c][5] <= zext(WW'(ts_sec_q[c]));
          sh_q[c][6] <= zext(WW'(ts_nsec_q[c]));
          sh_q[c][7] <= zext(WW'(last_size_q[c]));
        end
      end
    end
  end

  assign bus.snapshot_done = snapshot_done_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
endmodule
